// File: rtl/pipo_reg_arbiter.sv
// Round-robin write arbiter/sequencer for a PIPO register whose DFF cells lack a load enable.
// Define PIPO_ARB_VERIFY_EN to add the CHECK state with readback compare and err reporting.
module pipo_reg_arbiter #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic                  err,
   output logic                  busy,
   output logic [WIDTH-1:0]      reg_d,
   input  logic [WIDTH-1:0]      reg_q
);
   localparam int PW = $clog2(NREQ);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
`ifdef PIPO_ARB_VERIFY_EN
   localparam logic [1:0] ST_CHECK = 2'd2;
`endif

   logic [1:0]      state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            busy_q, busy_d;

   logic [PW:0]     pick_s;
   logic            found_s;
   logic [PW-1:0]   sel_s;
   logic [NREQ-1:0] onehot_s;

   // Returns {found, index} of the first set request after pointer p, wrapping modulo NREQ.
   function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
      logic          found;
      logic [PW-1:0] sel;
      int            idx;
      found = 1'b0;
      sel   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(p) + k) % NREQ;
         if (!found && r[idx]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
      return {found, sel};
   endfunction

   assign pick_s   = rr_pick(req, ptr_q);
   assign found_s  = pick_s[PW];
   assign sel_s    = pick_s[PW-1:0];
   assign onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << sel_s;

   // Next-state, arbitration and output-register computation.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      gnt_d   = gnt_q;
      ack_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               state_d = ST_WRITE;
               ptr_d   = sel_s;
               data_d  = wdata[int'(sel_s)*WIDTH +: WIDTH];
               gnt_d   = onehot_s;
`ifndef PIPO_ARB_VERIFY_EN
               ack_d   = onehot_s;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
`ifdef PIPO_ARB_VERIFY_EN
            state_d = ST_CHECK;
            ack_d   = gnt_q;
`else
            state_d = ST_IDLE;
            gnt_d   = '0;
`endif
         end
`ifdef PIPO_ARB_VERIFY_EN
         ST_CHECK: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
`endif
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset also aborts any in-flight write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= PW'(NREQ - 1);
         data_q  <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   // Outside WRITE the cells re-capture their own Q, since they have no load enable.
   assign reg_d = (state_q == ST_WRITE) ? data_q : reg_q;
   assign gnt   = gnt_q;
   assign ack   = ack_q;
   assign busy  = busy_q;

`ifdef PIPO_ARB_VERIFY_EN
   // Readback is only valid during CHECK, so err is decoded from flop outputs alone.
   assign err = (state_q == ST_CHECK) && (reg_q != data_q);
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_pipo_reg_arbiter.sv
// Directed bench for pipo_reg_arbiter with a behavioural PIPO register and stuck-at fault injection.
module tb_pipo_reg_arbiter;
   logic        clk;
   logic        reset;
   logic [2:0]  req;
   logic [11:0] wdata;
   logic [2:0]  gnt;
   logic [2:0]  ack;
   logic        err;
   logic        busy;
   logic [3:0]  reg_d;
   logic [3:0]  reg_q;
   logic [3:0]  reg_q_r;
   logic [3:0]  stuck0;
   int          n_tests;
   int          n_fail;

   pipo_reg_arbiter #(.WIDTH(4), .NREQ(3)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .ack   (ack),
      .err   (err),
      .busy  (busy),
      .reg_d (reg_d),
      .reg_q (reg_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PIPO register model sharing the arbiter's reset; stuck0 forces bits low on Q.
   always @(posedge clk or posedge reset) begin
      if (reset) reg_q_r <= 4'h0;
      else       reg_q_r <= reg_d;
   end
   assign reg_q = reg_q_r & ~stuck0;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 3'b000; wdata = 12'h000; stuck0 = 4'h0;
      cyc(); cyc();
      n_tests++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rst_gnt: got %b want 000", gnt); end
      n_tests++; if (ack !== 3'b000) begin n_fail++; $display("FAIL rst_ack: got %b want 000", ack); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_tests++; if (reg_d !== 4'h0) begin n_fail++; $display("FAIL rst_reg_d: got %h want 0", reg_d); end
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_single_write();
      req = 3'b001; wdata = 12'h00A;
      cyc();
      n_tests++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL single_gnt: got %b want 001", gnt); end
      n_tests++; if (reg_d !== 4'hA) begin n_fail++; $display("FAIL single_reg_d: got %h want a", reg_d); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy1: got %b want 1", busy); end
`ifdef PIPO_ARB_VERIFY_EN
      n_tests++; if (ack !== 3'b000) begin n_fail++; $display("FAIL single_ack_early: got %b want 000", ack); end
      cyc();
      n_tests++; if (ack !== 3'b001) begin n_fail++; $display("FAIL single_ack: got %b want 001", ack); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err); end
      n_tests++; if (reg_q !== 4'hA) begin n_fail++; $display("FAIL single_reg_q: got %h want a", reg_q); end
      req = 3'b000;
      cyc();
`else
      n_tests++; if (ack !== 3'b001) begin n_fail++; $display("FAIL single_ack: got %b want 001", ack); end
      req = 3'b000;
      cyc();
      n_tests++; if (reg_q !== 4'hA) begin n_fail++; $display("FAIL single_reg_q: got %h want a", reg_q); end
      n_tests++; if (ack !== 3'b000) begin n_fail++; $display("FAIL single_ack_clr: got %b want 000", ack); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err); end
`endif
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
      n_tests++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL single_gnt_clr: got %b want 000", gnt); end
      for (int i = 0; i < 10; i++) cyc();
      n_tests++; if (reg_q !== 4'hA) begin n_fail++; $display("FAIL hold_reg_q: got %h want a", reg_q); end
      n_tests++; if (reg_d !== 4'hA) begin n_fail++; $display("FAIL hold_reg_d: got %h want a", reg_d); end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_g;
      logic [3:0] exp_d;
      reset = 1'b1; cyc(); reset = 1'b0;
      req = 3'b111; wdata = 12'h321;
      for (int k = 0; k < 4; k++) begin
         exp_g = 3'b001 << (k % 3);
         exp_d = 4'((k % 3) + 1);
         cyc();
         n_tests++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt, exp_g); end
         n_tests++; if (reg_d !== exp_d) begin n_fail++; $display("FAIL rr_reg_d%0d: got %h want %h", k, reg_d, exp_d); end
`ifndef PIPO_ARB_VERIFY_EN
         n_tests++; if (ack !== exp_g) begin n_fail++; $display("FAIL rr_ack%0d: got %b want %b", k, ack, exp_g); end
`endif
         cyc();
         n_tests++; if (reg_q !== exp_d) begin n_fail++; $display("FAIL rr_reg_q%0d: got %h want %h", k, reg_q, exp_d); end
`ifdef PIPO_ARB_VERIFY_EN
         n_tests++; if (ack !== exp_g) begin n_fail++; $display("FAIL rr_ack%0d: got %b want %b", k, ack, exp_g); end
         cyc();
`endif
      end
      req = 3'b000;
   endtask

   task automatic test_fault();
      req = 3'b010; wdata = 12'h050; stuck0 = 4'h1;
      cyc();
      n_tests++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL fault_gnt: got %b want 010", gnt); end
`ifdef PIPO_ARB_VERIFY_EN
      cyc();
      n_tests++; if (ack !== 3'b010) begin n_fail++; $display("FAIL fault_ack: got %b want 010", ack); end
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL fault_err: got %b want 1", err); end
      req = 3'b000;
      cyc();
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL fault_err_pulse: got %b want 0", err); end
`else
      n_tests++; if (ack !== 3'b010) begin n_fail++; $display("FAIL fault_ack: got %b want 010", ack); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL fault_err_off1: got %b want 0", err); end
      req = 3'b000;
      cyc();
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL fault_err_off2: got %b want 0", err); end
`endif
      n_tests++; if (reg_q !== 4'h4) begin n_fail++; $display("FAIL fault_reg_q: got %h want 4", reg_q); end
      stuck0 = 4'h0;
   endtask

   task automatic test_wdata_change();
      req = 3'b100; wdata = 12'h600;
      cyc();
      n_tests++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL wchg_gnt: got %b want 100", gnt); end
      n_tests++; if (reg_d !== 4'h6) begin n_fail++; $display("FAIL wchg_reg_d: got %h want 6", reg_d); end
`ifndef PIPO_ARB_VERIFY_EN
      n_tests++; if (ack !== 3'b100) begin n_fail++; $display("FAIL wchg_ack: got %b want 100", ack); end
`endif
      wdata = 12'hF00; req = 3'b000;
      cyc();
      n_tests++; if (reg_q !== 4'h6) begin n_fail++; $display("FAIL wchg_reg_q: got %h want 6", reg_q); end
`ifdef PIPO_ARB_VERIFY_EN
      n_tests++; if (ack !== 3'b100) begin n_fail++; $display("FAIL wchg_ack: got %b want 100", ack); end
      cyc();
`endif
   endtask

   task automatic test_reset_mid();
      req = 3'b001; wdata = 12'h009;
      cyc();
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
      #2 reset = 1'b1;
      #1;
      n_tests++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rmid_gnt: got %b want 000", gnt); end
      n_tests++; if (ack !== 3'b000) begin n_fail++; $display("FAIL rmid_ack: got %b want 000", ack); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b want 0", err); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
      n_tests++; if (reg_q !== 4'h0) begin n_fail++; $display("FAIL rmid_reg_q: got %h want 0", reg_q); end
      req = 3'b000;
      cyc();
      n_tests++; if (ack !== 3'b000) begin n_fail++; $display("FAIL rmid_no_ack: got %b want 000", ack); end
      reset = 1'b0;
      req = 3'b010; wdata = 12'h070;
      cyc();
      n_tests++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rmid_regrant: got %b want 010", gnt); end
`ifdef PIPO_ARB_VERIFY_EN
      cyc();
      req = 3'b000;
      cyc();
`else
      req = 3'b000;
      cyc();
`endif
      n_tests++; if (reg_q !== 4'h7) begin n_fail++; $display("FAIL rmid_reg_q2: got %h want 7", reg_q); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_g [2];
      logic [3:0] exp_d [2];
      exp_g[0] = 3'b100; exp_d[0] = 4'hC;
      exp_g[1] = 3'b001; exp_d[1] = 4'h3;
      req = 3'b101; wdata = 12'hC03;
      for (int k = 0; k < 2; k++) begin
         cyc();
         n_tests++; if (gnt !== exp_g[k]) begin n_fail++; $display("FAIL b2b_gnt%0d: got %b want %b", k, gnt, exp_g[k]); end
         n_tests++; if (reg_d !== exp_d[k]) begin n_fail++; $display("FAIL b2b_reg_d%0d: got %h want %h", k, reg_d, exp_d[k]); end
         cyc();
`ifdef PIPO_ARB_VERIFY_EN
         n_tests++; if (ack !== exp_g[k]) begin n_fail++; $display("FAIL b2b_ack%0d: got %b want %b", k, ack, exp_g[k]); end
         cyc();
`endif
      end
      req = 3'b000;
      cyc();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
      n_tests++; if (reg_q !== 4'h3) begin n_fail++; $display("FAIL b2b_reg_q: got %h want 3", reg_q); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_single_write();
      test_round_robin();
      test_fault();
      test_wdata_change();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
